// File: rtl/roce_stack_dm_cmd_tracker.sv
// Datamover command tracker: tags and forwards commands, counts in-flight commands,
// and checks returning status for errors and in-order tags.
module roce_stack_dm_cmd_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic         clk_i,
    input  logic         aresetn_i,
    input  logic         s_cmd_valid_i,
    output logic         s_cmd_ready_o,
    input  logic [103:0] s_cmd_data_i,
    output logic         m_cmd_valid_o,
    input  logic         m_cmd_ready_i,
    output logic [103:0] m_cmd_data_o,
    input  logic         s_sts_valid_i,
    output logic         s_sts_ready_o,
    input  logic [7:0]   s_sts_data_i,
    input  logic         clear_err_i,
    output logic [4:0]   outstanding_o,
    output logic         err_o,
    output logic [3:0]   err_tag_o,
    output logic [15:0]  err_cnt_o,
    output logic [31:0]  cmpl_cnt_o,
    output logic         idle_o
);

    localparam logic [4:0] MaxOut = 5'(MAX_OUTSTANDING);

    logic         m_valid_q, m_valid_d;
    logic [103:0] m_data_q, m_data_d;
    logic         sts_ready_q;
    logic [4:0]   outstanding_q, outstanding_d;
    logic [3:0]   issue_tag_q, issue_tag_d;
    logic [3:0]   exp_tag_q, exp_tag_d;
    logic         err_q, err_d;
    logic [3:0]   err_tag_q, err_tag_d;
    logic [15:0]  err_cnt_q, err_cnt_d;
    logic [31:0]  cmpl_cnt_q, cmpl_cnt_d;

    logic cmd_hs, sts_hs, has_out, sts_err;

    assign s_cmd_ready_o = aresetn_i && (!m_valid_q || m_cmd_ready_i) && (outstanding_q < MaxOut);
    assign cmd_hs        = s_cmd_valid_i && s_cmd_ready_o;
    assign sts_hs        = s_sts_valid_i && sts_ready_q;
    assign has_out       = (outstanding_q != 5'd0);
    // Status with nothing in flight is always an error, regardless of its contents.
    assign sts_err       = (s_sts_data_i[6:4] != 3'b000) || !s_sts_data_i[7] ||
                           (s_sts_data_i[3:0] != exp_tag_q) || !has_out;

    always_comb begin
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        issue_tag_d   = issue_tag_q;
        outstanding_d = outstanding_q;
        exp_tag_d     = exp_tag_q;
        cmpl_cnt_d    = cmpl_cnt_q;
        err_d         = err_q;
        err_tag_d     = err_tag_q;
        err_cnt_d     = err_cnt_q;

        if (cmd_hs) begin
            m_valid_d   = 1'b1;
            m_data_d    = {s_cmd_data_i[103:100], issue_tag_q, s_cmd_data_i[95:0]};
            issue_tag_d = issue_tag_q + 4'd1;
        end else if (m_cmd_ready_i) begin
            m_valid_d = 1'b0;
        end

        if (sts_hs && has_out) begin
            exp_tag_d  = exp_tag_q + 4'd1;
            cmpl_cnt_d = cmpl_cnt_q + 32'd1;
        end

        case ({cmd_hs, sts_hs && has_out})
            2'b10:   outstanding_d = outstanding_q + 5'd1;
            2'b01:   outstanding_d = outstanding_q - 5'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // A new error outranks a simultaneous clear and restarts the count at 1.
        if (sts_hs && sts_err) begin
            err_d = 1'b1;
            if (clear_err_i || !err_q) begin
                err_tag_d = s_sts_data_i[3:0];
            end
            if (clear_err_i) begin
                err_cnt_d = 16'd1;
            end else if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end else if (clear_err_i) begin
            err_d     = 1'b0;
            err_tag_d = 4'd0;
            err_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            sts_ready_q   <= 1'b0;
            outstanding_q <= '0;
            issue_tag_q   <= '0;
            exp_tag_q     <= '0;
            err_q         <= 1'b0;
            err_tag_q     <= '0;
            err_cnt_q     <= '0;
            cmpl_cnt_q    <= '0;
        end else begin
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            sts_ready_q   <= 1'b1;
            outstanding_q <= outstanding_d;
            issue_tag_q   <= issue_tag_d;
            exp_tag_q     <= exp_tag_d;
            err_q         <= err_d;
            err_tag_q     <= err_tag_d;
            err_cnt_q     <= err_cnt_d;
            cmpl_cnt_q    <= cmpl_cnt_d;
        end
    end

    assign m_cmd_valid_o = m_valid_q;
    assign m_cmd_data_o  = m_data_q;
    assign s_sts_ready_o = sts_ready_q;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;
    assign err_tag_o     = err_tag_q;
    assign err_cnt_o     = err_cnt_q;
    assign cmpl_cnt_o    = cmpl_cnt_q;
    assign idle_o        = (outstanding_q == 5'd0) && !m_valid_q;

endmodule

// File: tb/tb_roce_stack_dm_cmd_tracker.sv
// Scoreboard bench for roce_stack_dm_cmd_tracker: directed scenarios plus random traffic
// against a queue/counter reference model; checks sampled on the falling edge.
module tb_roce_stack_dm_cmd_tracker;

    localparam int MaxOut = 8;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_cmd_valid = 1'b0;
    logic         s_cmd_ready;
    logic [103:0] s_cmd_data = '0;
    logic         m_cmd_valid;
    logic         m_cmd_ready = 1'b0;
    logic [103:0] m_cmd_data;
    logic         s_sts_valid = 1'b0;
    logic         s_sts_ready;
    logic [7:0]   s_sts_data = '0;
    logic         clear_err = 1'b0;
    logic [4:0]   outstanding;
    logic         err;
    logic [3:0]   err_tag;
    logic [15:0]  err_cnt;
    logic [31:0]  cmpl_cnt;
    logic         idle;

    roce_stack_dm_cmd_tracker #(.MAX_OUTSTANDING(MaxOut)) dut (
        .clk_i         (clk),
        .aresetn_i     (aresetn),
        .s_cmd_valid_i (s_cmd_valid),
        .s_cmd_ready_o (s_cmd_ready),
        .s_cmd_data_i  (s_cmd_data),
        .m_cmd_valid_o (m_cmd_valid),
        .m_cmd_ready_i (m_cmd_ready),
        .m_cmd_data_o  (m_cmd_data),
        .s_sts_valid_i (s_sts_valid),
        .s_sts_ready_o (s_sts_ready),
        .s_sts_data_i  (s_sts_data),
        .clear_err_i   (clear_err),
        .outstanding_o (outstanding),
        .err_o         (err),
        .err_tag_o     (err_tag),
        .err_cnt_o     (err_cnt),
        .cmpl_cnt_o    (cmpl_cnt),
        .idle_o        (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    bit running  = 1'b0;

    // Reference model: state the DUT should show after the most recent rising edge.
    logic [103:0] exp_q[$];
    int           m_out = 0, m_exp = 0, m_issue = 0, m_err_tag = 0, m_err_cnt = 0;
    bit           m_err = 1'b0, m_sts_rdy = 1'b0;
    logic [31:0]  m_cmpl = '0;

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            bit           cmd_rdy, cmd_hs, m_hs, sts_hs, has, bad;
            logic [103:0] d;
            cmd_rdy = aresetn && (exp_q.size() == 0 || m_cmd_ready) && (m_out < MaxOut);
            check("m_cmd_valid", m_cmd_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("m_cmd_data", m_cmd_data, exp_q[0]);
            check("s_cmd_ready", s_cmd_ready, cmd_rdy);
            check("s_sts_ready", s_sts_ready, m_sts_rdy);
            check("outstanding", outstanding, m_out);
            check("err", err, m_err);
            check("err_tag", err_tag, m_err_tag);
            check("err_cnt", err_cnt, m_err_cnt);
            check("cmpl_cnt", cmpl_cnt, m_cmpl);
            check("idle", idle, (m_out == 0) && (exp_q.size() == 0));

            if (!aresetn) begin
                exp_q.delete();
                m_out = 0; m_exp = 0; m_issue = 0; m_err = 0; m_err_tag = 0; m_err_cnt = 0;
                m_cmpl = '0; m_sts_rdy = 0;
            end else begin
                cmd_hs = s_cmd_valid && cmd_rdy;
                m_hs   = (exp_q.size() != 0) && m_cmd_ready;
                sts_hs = s_sts_valid && m_sts_rdy;
                if (m_hs) void'(exp_q.pop_front());
                if (cmd_hs) begin
                    d = s_cmd_data;
                    d[99:96] = 4'(m_issue);
                    exp_q.push_back(d);
                    m_issue = (m_issue + 1) % 16;
                end
                has = m_out > 0;
                if (sts_hs) begin
                    bad = (s_sts_data[6:4] != 0) || !s_sts_data[7] ||
                          (int'(s_sts_data[3:0]) != m_exp) || !has;
                    if (has) begin
                        m_cmpl = m_cmpl + 1;
                        m_exp  = (m_exp + 1) % 16;
                    end
                end else begin
                    bad = 1'b0;
                end
                if (bad) begin
                    if (clear_err || !m_err) m_err_tag = int'(s_sts_data[3:0]);
                    m_err_cnt = clear_err ? 1 : (m_err_cnt < 65535 ? m_err_cnt + 1 : 65535);
                    m_err = 1'b1;
                end else if (clear_err) begin
                    m_err = 1'b0; m_err_tag = 0; m_err_cnt = 0;
                end
                m_out = m_out + int'(cmd_hs) - int'(sts_hs && has);
                m_sts_rdy = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [103:0] data);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        s_cmd_valid = 1'b1;
        s_cmd_data  = data;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = s_cmd_ready;
            cyc();
            n++;
        end
        s_cmd_valid = 1'b0;
        if (!hs) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_cmd_timeout: got no handshake, expected one within 100 cycles");
        end
    endtask

    task automatic send_sts(input logic [7:0] sts);
        s_sts_valid = 1'b1;
        s_sts_data  = sts;
        cyc();
        s_sts_valid = 1'b0;
    endtask

    task automatic drain();
        m_cmd_ready = 1'b1;
        for (int i = 0; i < 40 && m_out > 0; i++) send_sts({4'h8, 4'(m_exp)});
        cyc();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) cyc();
        aresetn = 1'b1;
        cyc();
    endtask

    initial begin
        cyc();
        running = 1'b1;
        do_reset();

        // Single command, then good status.
        m_cmd_ready = 1'b1;
        send_cmd({4'h0, 4'hF, 32'h0, 32'h0000_1000, 32'h0000_0040});
        cyc();
        send_sts(8'h80);
        repeat (2) cyc();

        // Fill to the limit; one status frees exactly one slot.
        s_cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_cmd_data = {72'h0, 32'(i)};
            if (i == 10) begin
                s_sts_valid = 1'b1;
                s_sts_data  = {4'h8, 4'(m_exp)};
            end
            cyc();
            s_sts_valid = 1'b0;
        end
        s_cmd_valid = 1'b0;
        drain();

        // Twenty in-order commands and statuses: tag wrap.
        for (int i = 0; i < 20; i++) begin
            send_cmd({$urandom, $urandom, $urandom, $urandom});
            send_sts({4'h8, 4'(m_exp)});
        end
        drain();

        // Two error statuses.
        send_cmd(104'h1);
        send_cmd(104'h2);
        send_sts({4'hC, 4'(m_exp)});
        send_sts({4'h1, 4'(m_exp)});
        cyc();
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;

        // Status with nothing outstanding, then clear; then error coinciding with clear.
        send_sts(8'h80);
        clear_err = 1'b1;
        cyc();
        s_sts_valid = 1'b1;
        s_sts_data  = 8'h85;
        cyc();
        s_sts_valid = 1'b0;
        clear_err   = 1'b0;
        cyc();

        // Back-pressure: held command must stay stable.
        m_cmd_ready = 1'b0;
        send_cmd({$urandom, $urandom, $urandom, $urandom});
        s_cmd_valid = 1'b1;
        repeat (5) cyc();
        m_cmd_ready = 1'b1;
        cyc();
        s_cmd_valid = 1'b0;
        drain();

        // Reset with commands held and in flight.
        m_cmd_ready = 1'b0;
        send_cmd(104'hABC);
        do_reset();
        m_cmd_ready = 1'b1;
        send_cmd(104'hDEF);
        drain();

        // Random traffic, one reset mid-way.
        for (int i = 0; i < 3000; i++) begin
            s_cmd_valid = 1'($urandom % 2);
            s_cmd_data  = {$urandom, $urandom, $urandom, $urandom};
            m_cmd_ready = ($urandom % 4) != 0;
            s_sts_valid = ($urandom % 3) == 0;
            s_sts_data  = ($urandom % 8 == 0) ? 8'($urandom) : {4'h8, 4'(m_exp)};
            clear_err   = ($urandom % 50) == 0;
            aresetn     = (i != 1500);
            cyc();
        end
        s_cmd_valid = 1'b0;
        s_sts_valid = 1'b0;
        clear_err   = 1'b0;
        aresetn     = 1'b1;
        drain();
        repeat (2) cyc();

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/roce_stack_dm_cmd_tracker.md
ROCE_STACK_DM_CMD_TRACKER -- requirements
Module: roce_stack_dm_cmd_tracker

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, legal 1..16: maximum datamover commands in flight per direction.
REQ-002 SHALL have port clk_i, input, 1: single clock; all logic rising-edge.
REQ-003 SHALL have port aresetn_i, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports s_cmd_valid_i (in, 1), s_cmd_ready_o (out, 1), s_cmd_data_i (in, 104): command from request handler.
REQ-005 SHALL have ports m_cmd_valid_o (out, 1), m_cmd_ready_i (in, 1), m_cmd_data_o (out, 104): command to datamover.
REQ-006 SHALL have ports s_sts_valid_i (in, 1), s_sts_ready_o (out, 1), s_sts_data_i (in, 8): datamover status; [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY.
REQ-007 SHALL have port clear_err_i, input, 1: clears sticky error state.
REQ-008 SHALL have ports outstanding_o (out, 5), err_o (out, 1), err_tag_o (out, 4), err_cnt_o (out, 16), cmpl_cnt_o (out, 32), idle_o (out, 1).

Function
REQ-009 SHALL hold one registered command stage; s_cmd_ready_o = (!m_cmd_valid_o || m_cmd_ready_i) && (outstanding_o < MAX_OUTSTANDING), combinational.
REQ-010 On s_cmd handshake SHALL load m_cmd_data_o next cycle with bits [95:0] and [103:100] copied, bits [99:96] replaced by issue tag; m_cmd_valid_o set; latency exactly 1 cycle.
REQ-011 m_cmd_valid_o/m_cmd_data_o SHALL remain stable until m_cmd_ready_i; back-to-back accept/issue SHALL sustain 1 command/cycle.
REQ-012 Issue tag SHALL be a 4-bit counter, increment per accepted command, wrap 15->0.
REQ-013 outstanding_o SHALL increment on s_cmd handshake, decrement on accepted valid status; both in same cycle -> unchanged.
REQ-014 s_sts_ready_o SHALL be 1 whenever out of reset; status never back-pressured.
REQ-015 Expected tag SHALL be a 4-bit counter, increment per accepted status while outstanding_o > 0, wrap 15->0.
REQ-016 Status error = any of INTERR/DECERR/SLVERR set, OKAY clear, or TAG != expected tag.
REQ-017 Status received with outstanding_o == 0 SHALL be an error; outstanding_o and expected tag unchanged, cmpl_cnt_o unchanged.
REQ-018 Error SHALL set err_o (sticky), latch err_tag_o = received TAG on first error only, increment err_cnt_o saturating at 0xFFFF.
REQ-019 Every status accepted with outstanding_o > 0 (error or not) SHALL increment cmpl_cnt_o, wrapping at 2^32.
REQ-020 clear_err_i SHALL clear err_o, err_tag_o, err_cnt_o next cycle; simultaneous new error takes priority: err_o=1, err_tag_o=new TAG, err_cnt_o=1.
REQ-021 idle_o SHALL be 1 iff outstanding_o == 0 and m_cmd_valid_o == 0, combinational.
REQ-022 All status/counter outputs SHALL be registered, updating the cycle after the causing handshake.

Reset
REQ-023 With aresetn_i low at clock edge: m_cmd_valid_o=0, m_cmd_data_o=0, s_sts_ready_o=0, outstanding_o=0, both tag counters=0, err_o=0, err_tag_o=0, err_cnt_o=0, cmpl_cnt_o=0.
REQ-024 s_cmd_ready_o SHALL be 0 while aresetn_i is low.
REQ-025 Reset mid-transfer SHALL discard the held command and all in-flight tracking; first command after reset gets tag 0.

Verification
REQ-026 Single command BTT=0x40, addr 0x1000, m_cmd_ready_i=1 -> m_cmd_valid_o 1 cycle later, [99:96]=0, outstanding_o=1; status 0x80 -> outstanding_o=0, cmpl_cnt_o=1, err_o=0, idle_o=1.
REQ-027 MAX_OUTSTANDING=8, 10 commands, no status -> s_cmd_ready_o drops after 8th acceptance; one status 0x80 -> exactly one more accepted.
REQ-028 20 commands/statuses in order -> tags 0..15,0..3 on m_cmd_data_o[99:96]; no error; cmpl_cnt_o=20.
REQ-029 Status 0xC0 (SLVERR+OKAY) for tag 0, then 0x11 for tag 1 -> err_o=1, err_tag_o=0, err_cnt_o=2, outstanding decremented twice.
REQ-030 Status 0x80 with outstanding_o=0 -> err_o=1, err_cnt_o=1, outstanding_o=0, cmpl_cnt_o=0; clear_err_i pulse -> err_o=0, err_cnt_o=0.
REQ-031 m_cmd_ready_i=0 for 5 cycles with held command -> m_cmd_data_o stable, s_cmd_ready_o=0; same-cycle accept and status at outstanding 3 -> stays 3.
